// File: rtl/dtg.sv
// VGA-style display timing generator: free-running pixel/line counters with
// registered video_on, line/frame ticks and a configurable sync delay line.
module dtg #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clock,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_column,
  output logic [9:0] pixel_row,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] L_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] L_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] L_HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] L_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] L_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] L_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_col;
  logic [9:0] r_row;
  logic       r_video_on;
  logic       r_line_tick;
  logic       r_frame_tick;
  logic [1:0] r_sync0;

  logic       w_h_wrap;
  logic [9:0] w_col_next;
  logic [9:0] w_row_next;
  logic       w_hs_next;
  logic       w_vs_next;

  assign w_h_wrap   = (r_col == L_H_LAST);
  assign w_col_next = w_h_wrap ? 10'd0 : r_col + 10'd1;
  assign w_row_next = !w_h_wrap            ? r_row :
                      (r_row == L_V_LAST)  ? 10'd0 : r_row + 10'd1;

  assign w_hs_next = !((w_col_next >= L_HS_START) && (w_col_next < L_HS_END));
  assign w_vs_next = !((w_row_next >= L_VS_START) && (w_row_next < L_VS_END));

  // Every flag is computed from the next-state counts so it lines up with the counters.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= L_H_LAST;
      r_row        <= L_V_LAST;
      r_video_on   <= 1'b0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
      r_sync0      <= 2'b11;
    end else begin
      r_col        <= w_col_next;
      r_row        <= w_row_next;
      r_video_on   <= (w_col_next < L_H_ACT) && (w_row_next < L_V_ACT);
      r_line_tick  <= (w_col_next == 10'd0);
      r_frame_tick <= (w_col_next == 10'd0) && (w_row_next == 10'd0);
      r_sync0      <= {w_vs_next, w_hs_next};
    end
  end

  // Sync delay chain: element 0 is the zero-lag sync pair, element N is N clocks late.
  logic [1:0] w_chain [SYNC_DELAY+1];
  assign w_chain[0] = r_sync0;

  generate
    for (genvar gi = 0; gi < SYNC_DELAY; gi++) begin : g_stage
      logic [1:0] r_q;
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_q <= 2'b11;
        else        r_q <= w_chain[gi];
      end
      assign w_chain[gi+1] = r_q;
    end
  endgenerate

  assign hsync        = w_chain[SYNC_DELAY][0];
  assign vsync        = w_chain[SYNC_DELAY][1];
  assign video_on     = r_video_on;
  assign pixel_column = r_col;
  assign pixel_row    = r_row;
  assign line_tick    = r_line_tick;
  assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_dtg.sv
// Bench for dtg: three instances (sync delay 0, 1, 3) on a reduced raster,
// checked against an arithmetic model indexed by clocks since reset release.
module tb_dtg;
  localparam int HA = 64, HF = 4, HS = 8, HB = 6;
  localparam int VA = 20, VF = 3, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DLY [3] = '{0, 1, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] col [3];
  logic [9:0] row [3];
  logic hs [3], vs [3], vid [3], lt [3], ft [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      dtg #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_DELAY(DLY[gi])
      ) u_dut (
        .clock(clk), .rst_n(rst_n),
        .hsync(hs[gi]), .vsync(vs[gi]), .video_on(vid[gi]),
        .pixel_column(col[gi]), .pixel_row(row[gi]),
        .line_tick(lt[gi]), .frame_tick(ft[gi])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;
  int idx = -1;  // clocks since reset release minus one; -1 while in reset

  // ---------------- reference model ----------------
  function automatic int mcol(int i);
    return (i < 0) ? HT - 1 : i % HT;
  endfunction
  function automatic int mrow(int i);
    return (i < 0) ? VT - 1 : (i / HT) % VT;
  endfunction
  function automatic logic mhs(int i, int d);
    int c;
    if (i < 0 || i - d < 0) return 1'b1;
    c = mcol(i - d);
    return !(c >= HA + HF && c < HA + HF + HS);
  endfunction
  function automatic logic mvs(int i, int d);
    int r;
    if (i < 0 || i - d < 0) return 1'b1;
    r = mrow(i - d);
    return !(r >= VA + VF && r < VA + VF + VS);
  endfunction
  function automatic logic [24:0] exp_vec(int i, int d);
    logic v, l, f;
    v = (i >= 0) && mcol(i) < HA && mrow(i) < VA;
    l = (i >= 0) && mcol(i) == 0;
    f = l && mrow(i) == 0;
    return {10'(mcol(i)), 10'(mrow(i)), v, mhs(i, d), mvs(i, d), l, f};
  endfunction
  function automatic logic [24:0] got_vec(int k);
    return {col[k], row[k], vid[k], hs[k], vs[k], lt[k], ft[k]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) idx++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_vec(k) !== exp_vec(-1, DLY[k])) begin
        errors++;
        $display("FAIL reset_state dut%0d got=%h exp=%h", k, got_vec(k), exp_vec(-1, DLY[k]));
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_first_edge();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({col[k], row[k], vid[k], lt[k], ft[k]} !== {10'd0, 10'd0, 3'b111}) begin
        errors++;
        $display("FAIL first_edge dut%0d got col=%0d row=%0d vid=%b lt=%b ft=%b exp col=0 row=0 vid=1 lt=1 ft=1",
                 k, col[k], row[k], vid[k], lt[k], ft[k]);
      end
    end
    $display("test_first_edge done idx=%0d", idx);
  endtask

  task automatic test_line();
    int first [3];
    int width [3];
    int vcount;
    vcount = 0;
    for (int k = 0; k < 3; k++) begin first[k] = -1; width[k] = 0; end
    for (int n = 0; n < HT; n++) begin
      if (vid[1]) vcount++;
      for (int k = 0; k < 3; k++)
        if (hs[k] == 1'b0) begin
          if (first[k] < 0) first[k] = int'(col[k]);
          width[k]++;
        end
      step();
    end
    checks++;
    if (vcount != HA) begin
      errors++;
      $display("FAIL line_video_count got=%0d exp=%0d", vcount, HA);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (first[k] != HA + HF + DLY[k]) begin
        errors++;
        $display("FAIL hsync_start dut%0d got=%0d exp=%0d", k, first[k], HA + HF + DLY[k]);
      end
      checks++;
      if (width[k] != HS) begin
        errors++;
        $display("FAIL hsync_width dut%0d got=%0d exp=%0d", k, width[k], HS);
      end
    end
    checks++;
    if ({lt[1], ft[1], col[1], row[1]} !== {1'b1, 1'b0, 10'd0, 10'd1}) begin
      errors++;
      $display("FAIL line_tick_repeat got lt=%b ft=%b col=%0d row=%0d exp lt=1 ft=0 col=0 row=1",
               lt[1], ft[1], col[1], row[1]);
    end
    $display("test_line done video=%0d hs_start=%0d/%0d/%0d", vcount, first[0], first[1], first[2]);
  endtask

  task automatic test_frame();
    int vcount, blank_vid, vslow, bad;
    vcount = 0; blank_vid = 0; vslow = 0; bad = 0;
    for (int n = 0; n < HT * VT; n++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(idx, DLY[k])) begin
          errors++;
          bad++;
          if (bad <= 20)
            $display("FAIL frame_outputs dut%0d idx=%0d got=%h exp=%h", k, idx, got_vec(k), exp_vec(idx, DLY[k]));
        end
      end
      if (vid[1]) vcount++;
      if (vid[1] && int'(row[1]) >= VA) blank_vid++;
      if (!vs[1]) vslow++;
      step();
    end
    checks++;
    if (vcount != HA * VA) begin
      errors++;
      $display("FAIL frame_video_count got=%0d exp=%0d", vcount, HA * VA);
    end
    checks++;
    if (blank_vid != 0) begin
      errors++;
      $display("FAIL video_in_vblank got=%0d exp=0", blank_vid);
    end
    checks++;
    if (vslow != VS * HT) begin
      errors++;
      $display("FAIL vsync_low_count got=%0d exp=%0d", vslow, VS * HT);
    end
    $display("test_frame done video=%0d vsync_low=%0d", vcount, vslow);
  endtask

  task automatic test_back_to_back();
    int ticks, lticks, last, period;
    ticks = 0; lticks = 0; last = -1; period = -1;
    for (int n = 0; n < 2 * HT * VT; n++) begin
      if (lt[1]) lticks++;
      if (ft[1]) begin
        if (last >= 0) period = idx - last;
        last = idx;
        ticks++;
      end
      step();
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL frame_tick_count got=%0d exp=2", ticks);
    end
    checks++;
    if (period != HT * VT) begin
      errors++;
      $display("FAIL frame_tick_period got=%0d exp=%0d", period, HT * VT);
    end
    checks++;
    if (lticks != 2 * VT) begin
      errors++;
      $display("FAIL line_tick_count got=%0d exp=%0d", lticks, 2 * VT);
    end
    $display("test_back_to_back done frames=%0d period=%0d lines=%0d", ticks, period, lticks);
  endtask

  task automatic test_async_reset();
    int n;
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(HT, 2 * HT * VT));
      for (int s = 0; s < n; s++) begin
        checks++;
        if ({col[1], row[1]} !== {10'(mcol(idx)), 10'(mrow(idx))}) begin
          errors++;
          $display("FAIL run_position idx=%0d got col=%0d row=%0d exp col=%0d row=%0d",
                   idx, col[1], row[1], mcol(idx), mrow(idx));
        end
        step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(-1, DLY[k])) begin
          errors++;
          $display("FAIL async_reset dut%0d got=%h exp=%h", k, got_vec(k), exp_vec(-1, DLY[k]));
        end
      end
      idx = -1;
      step();
      checks++;
      if (col[1] !== 10'(HT - 1)) begin
        errors++;
        $display("FAIL reset_hold got col=%0d exp=%0d", col[1], HT - 1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(0, DLY[k])) begin
          errors++;
          $display("FAIL restart dut%0d got=%h exp=%h", k, got_vec(k), exp_vec(0, DLY[k]));
        end
      end
      $display("test_async_reset iter=%0d reset after %0d clocks", it, n);
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_line();
    test_frame();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
